// File: rtl/popcount_accum_pipe.sv
// Pipelined popcount: 6:3 compressors on 6-bit groups, then a registered adder tree,
// followed by a saturating accumulate/output stage. The pipeline stalls as one unit.
module popcount_accum_pipe #(
  parameter int IN_W  = 36,
  parameter int ACC_W = 16,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int NG    = (IN_W + 5) / 6;

  // Per-stage fan-in: smallest d with d**PIPE >= NG, so entry 0 of the last stage
  // covers every group and the register stages split the tree depth evenly.
  function automatic int tree_fan();
    int fan, p;
    fan = 0;
    for (int d = 2; d <= 64; d++) begin
      p = 1;
      for (int i = 0; i < PIPE; i++) p = p * d;
      if (fan == 0 && p >= NG) fan = d;
    end
    return fan;
  endfunction

  localparam int FAN = tree_fan();

  // 6:3 compressor: two full adders, then a half adder and a full adder on the leftovers.
  function automatic logic [2:0] csa63(input logic [5:0] b);
    logic s1, c1, s2, c2, k;
    s1 = b[0] ^ b[1] ^ b[2];
    c1 = (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    s2 = b[3] ^ b[4] ^ b[5];
    c2 = (b[3] & b[4]) | (b[3] & b[5]) | (b[4] & b[5]);
    k  = s1 & s2;
    return {(c1 & c2) | (c1 & k) | (c2 & k), c1 ^ c2 ^ k, s1 ^ s2};
  endfunction

  logic [NG*6-1:0]  data_pad;
  logic [CNT_W-1:0] leaf  [NG];
  logic [CNT_W-1:0] src   [PIPE][NG];
  logic [CNT_W-1:0] sum_d [PIPE][NG];
  logic [CNT_W-1:0] sum_q [PIPE][NG];
  logic [CNT_W-1:0] cnt;
  logic [PIPE-1:0]  v_q, m_q, l_q;
  logic             adv;

  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  logic [ACC_W-1:0] acc_sat;

  assign data_pad = (NG*6)'(in_data);
  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;

  always_comb begin
    for (int g = 0; g < NG; g++) leaf[g] = CNT_W'(csa63(data_pad[g*6 +: 6]));
    for (int j = 0; j < NG; j++) src[0][j] = leaf[j];
    for (int s = 1; s < PIPE; s++) src[s] = sum_q[s-1];
    for (int s = 0; s < PIPE; s++) begin
      for (int j = 0; j < NG; j++) begin
        sum_d[s][j] = '0;
        for (int k = 0; k < FAN; k++)
          if (j*FAN + k < NG) sum_d[s][j] = sum_d[s][j] + src[s][j*FAN + k];
      end
    end
    // Entries past index 0 in the last stage are always zero; summing them is free.
    cnt = '0;
    for (int j = 0; j < NG; j++) cnt = cnt + sum_q[PIPE-1][j];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < PIPE; s++)
        for (int j = 0; j < NG; j++) sum_q[s][j] <= '0;
      v_q <= '0;
      m_q <= '0;
      l_q <= '0;
    end else if (clear) begin
      v_q <= '0;
    end else if (adv) begin
      sum_q  <= sum_d;
      v_q[0] <= in_valid;
      m_q[0] <= in_mode;
      l_q[0] <= in_last;
      for (int s = 1; s < PIPE; s++) begin
        v_q[s] <= v_q[s-1];
        m_q[s] <= m_q[s-1];
        l_q[s] <= l_q[s-1];
      end
    end
  end

  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(cnt);
  assign acc_ovf = acc_sum[ACC_W];
  assign acc_sat = acc_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (v_q[PIPE-1]) begin
        if (!m_q[PIPE-1]) begin
          out_valid <= 1'b1;
          out_count <= ACC_W'(cnt);
          out_sat   <= 1'b0;
        end else if (!l_q[PIPE-1]) begin
          acc_q <= acc_sat;
          sat_q <= sat_q | acc_ovf;
        end else begin
          out_valid <= 1'b1;
          out_count <= acc_sat;
          out_sat   <= sat_q | acc_ovf;
          acc_q     <= '0;
          sat_q     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/popcount_accum_pipe.md
Name: popcount_accum_pipe

Overview:
- Parametrised, pipelined population-count unit: counts the ones in an IN_W-bit input beat with a tree of 6:3 compressor stages, registered every few levels.
- Optionally accumulates counts across beats until a last flag, then emits the total.
- Feeds XNOR-popcount (binary-weight) MAC lanes and activation-sparsity statistics in the NPU datapath.
- Valid/ready on both sides; full backpressure.

Parameters:
IN_W, 36, input vector width in bits; legal range 6..256.
ACC_W, 16, accumulator and output width; must be at least CNT_W = clog2(IN_W+1).
PIPE, 2, number of register stages inside the compressor tree; legal range 1..4.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of pipeline and accumulator
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat
in_data  input  IN_W  bit vector to count
in_last  input  1  final beat of an accumulation group
in_mode  input  1  0 = per-beat count, 1 = accumulate until in_last
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_count  output  ACC_W  result, zero-extended count or accumulated sum
out_sat  output  1  result saturated at 2^ACC_W-1

Behaviour:
- Reset: all pipeline valid bits, the accumulator, out_valid, out_count and out_sat are 0. in_ready is 1 once reset_n is high.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready). The whole pipeline stalls as one unit; there is no skid buffer.
  - out_count and out_sat hold stable while out_valid && !out_ready.
- Pipeline:
  - Each stage carries valid, mode, last and a partial sum.
  - Bubbles (valid = 0) propagate normally and are never counted.
  - The tree reduces by 6:3 compression with full-adder leftovers. Registers are placed as evenly as possible over PIPE stages. The final stage yields a CNT_W-bit count.
  - mode and last are sampled per beat and travel with the data, so mode may change on every beat.
- Accumulate stage (one register after the tree):
  - Mode 0 beat: out_count <= zero-extended count; out_valid <= 1; out_sat <= 0. The accumulator is untouched.
  - Mode 1, last = 0: acc <= sat(acc + count); sat_flag |= overflow; no output.
  - Mode 1, last = 1: out_count <= sat(acc + count); out_sat <= sat_flag | overflow; out_valid <= 1. In the same cycle acc <= 0 and sat_flag <= 0.
  - Saturation clamps to 2^ACC_W-1. Once set, sat_flag is sticky until the group ends.
  - A mode 0 beat arriving mid-group is emitted on its own and does not disturb the pending group.
- Latency: PIPE+1 cycles from an accepted beat to out_valid, with no stall. Throughput is 1 beat per cycle.
- When out_valid && out_ready and no new result arrives, out_valid drops next cycle.
- clear:
  - Has priority over all other updates.
  - Next cycle: all pipeline valids = 0, acc = 0, sat_flag = 0, out_valid = 0.
  - in_ready stays as computed. A beat presented in the clear cycle is dropped.
- reset_n asserted mid-operation: immediate return to reset state, including any partial group.
- Combinational counting must be exact for all IN_W, including non-multiples of 6: unused tree inputs are tied to 0.

Test Plan:
1. IN_W=36, PIPE=2, mode 0, beats 0x0, 0xF_FFFF_FFFF, 0x5_5555_5555 back-to-back with out_ready=1 -> out_count 0, 36, 18 on cycles 3, 4, 5 after the first beat; out_sat=0.
2. Mode 1 group of 4 beats each with 10 ones, last on beat 4 -> exactly one result, out_count=40, out_sat=0; next group starts from 0.
3. ACC_W=8, mode 1, 10 beats of all-ones (36 each, 360 total) -> out_count=255, out_sat=1; following mode 0 beat of 7 ones -> out_count=7, out_sat=0.
4. out_ready held 0 for 5 cycles with a full pipeline -> in_ready=0, out_count stable, no beat lost or duplicated; order preserved after release. Also run a random in_valid/out_ready soak against a scoreboard.
5. Mode 0 beat (3 ones) between mode 1 beats of 5 and 6 ones (last) -> outputs 3 then 11.
6. clear asserted mid-group, then reset_n pulsed low mid-stream -> no output from the flushed beats; the next group sums from 0; all outputs 0 while in reset.
